lz4_block_decoder: RTL and testbench

Byte-serial LZ4 block decompressor: the inverse of the compression pipeline's encoder. It parses LZ4 sequences (token, literal-length extension, literals, 16-bit little-endian offset, match-length extension) from a byte stream and reproduces the original data. Match copies are served from an on-chip history RAM. It sits downstream of frame-header/checksum stripping and feeds the verification and readback path with decompressed bytes.

---
 rtl/lz4_block_decoder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lz4_block_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lz4_block_decoder.sv
// Byte-serial LZ4 block decompressor with on-chip history window for match copies.
// Parses token / length extensions / literals / offset and replays matches one byte every two cycles.
module lz4_block_decoder #(
  parameter int HIST_AW = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done,
  output logic        error,
  output logic [31:0] out_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_LIT_EXT, S_LIT, S_OFF_LO, S_OFF_HI,
    S_MAT_EXT, S_COPY_RD, S_COPY_WR, S_DONE, S_ERR
  } state_t;

  state_t               r_state, w_state_next;
  logic [31:0]          r_lit_len, w_lit_len_next;
  logic [3:0]           r_ml_nib, w_ml_nib_next;
  logic [15:0]          r_offset, w_offset_next;
  logic [31:0]          r_match_len, w_match_len_next;
  logic [HIST_AW-1:0]   r_wp, w_wp_next;
  logic [7:0]           r_out_data, w_out_data_next;
  logic                 r_out_valid, w_out_valid_next;
  logic                 r_out_last, w_out_last_next;
  logic                 r_done, w_done_next;
  logic                 r_error, w_error_next;
  logic [31:0]          r_out_count, w_out_count_next;

  logic [7:0]           r_mem [0:(2**HIST_AW)-1];
  logic [7:0]           r_ram_q;

  logic                 w_out_free;
  logic                 w_in_ready;
  logic                 w_acc;
  logic                 w_we;
  logic                 w_re;
  logic [7:0]           w_wdata;
  logic [HIST_AW-1:0]   w_raddr;
  logic [32:0]          w_lit_sum;
  logic [32:0]          w_mat_sum;
  logic [15:0]          w_offset_full;

  assign w_out_free    = !r_out_valid || out_ready;
  assign w_acc         = in_valid && w_in_ready;
  assign w_lit_sum     = {1'b0, r_lit_len} + {25'd0, in_data};
  assign w_mat_sum     = {1'b0, r_match_len} + {25'd0, in_data};
  assign w_offset_full = {in_data, r_offset[7:0]};
  assign w_raddr       = r_wp - HIST_AW'(r_offset);

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_TOKEN, S_LIT_EXT, S_OFF_LO, S_OFF_HI, S_MAT_EXT: w_in_ready = 1'b1;
      S_LIT:                                             w_in_ready = w_out_free;
      default:                                           w_in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_lit_len_next   = r_lit_len;
    w_ml_nib_next    = r_ml_nib;
    w_offset_next    = r_offset;
    w_match_len_next = r_match_len;
    w_wp_next        = r_wp;
    w_out_data_next  = r_out_data;
    w_out_valid_next = w_out_free ? 1'b0 : r_out_valid;
    w_out_last_next  = w_out_free ? 1'b0 : r_out_last;
    w_done_next      = r_done;
    w_error_next     = r_error;
    w_out_count_next = r_out_count;
    w_we             = 1'b0;
    w_re             = 1'b0;
    w_wdata          = in_data;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_done_next      = 1'b0;
          w_error_next     = 1'b0;
          w_out_count_next = 32'd0;
          w_wp_next        = '0;
          w_state_next     = S_TOKEN;
        end
      end

      S_TOKEN: begin
        if (w_acc) begin
          w_lit_len_next = {28'd0, in_data[7:4]};
          w_ml_nib_next  = in_data[3:0];
          if (in_last) begin
            // Only an empty trailing token may terminate a block here.
            if (in_data[7:4] == 4'd0) begin
              w_done_next  = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_error_next = 1'b1;
              w_state_next = S_ERR;
            end
          end else if (in_data[7:4] == 4'hF) begin
            w_state_next = S_LIT_EXT;
          end else if (in_data[7:4] != 4'd0) begin
            w_state_next = S_LIT;
          end else begin
            w_state_next = S_OFF_LO;
          end
        end
      end

      S_LIT_EXT: begin
        if (w_acc) begin
          w_lit_len_next = w_lit_sum[31:0];
          if (in_last || w_lit_sum[32]) begin
            w_error_next = 1'b1;
            w_state_next = S_ERR;
          end else if (in_data != 8'hFF) begin
            w_state_next = (w_lit_sum[31:0] == 32'd0) ? S_OFF_LO : S_LIT;
          end
        end
      end

      S_LIT: begin
        if (w_acc) begin
          w_out_data_next  = in_data;
          w_out_valid_next = 1'b1;
          w_out_last_next  = in_last && (r_lit_len == 32'd1);
          w_we             = 1'b1;
          w_wdata          = in_data;
          w_wp_next        = r_wp + 1'b1;
          w_out_count_next = r_out_count + 32'd1;
          w_lit_len_next   = r_lit_len - 32'd1;
          if (r_lit_len == 32'd1) begin
            if (in_last) begin
              w_done_next  = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_state_next = S_OFF_LO;
            end
          end else if (in_last) begin
            w_error_next = 1'b1;
            w_state_next = S_ERR;
          end
        end
      end

      S_OFF_LO: begin
        if (w_acc) begin
          w_offset_next = {r_offset[15:8], in_data};
          if (in_last) begin
            w_error_next = 1'b1;
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_OFF_HI;
          end
        end
      end

      S_OFF_HI: begin
        if (w_acc) begin
          w_offset_next = w_offset_full;
          if (in_last || (w_offset_full == 16'd0) ||
              ({16'd0, w_offset_full} > r_out_count)) begin
            w_error_next = 1'b1;
            w_state_next = S_ERR;
          end else if (r_ml_nib == 4'hF) begin
            w_match_len_next = 32'd19;
            w_state_next     = S_MAT_EXT;
          end else begin
            w_match_len_next = {28'd0, r_ml_nib} + 32'd4;
            w_state_next     = S_COPY_RD;
          end
        end
      end

      S_MAT_EXT: begin
        if (w_acc) begin
          w_match_len_next = w_mat_sum[31:0];
          if (in_last || w_mat_sum[32]) begin
            w_error_next = 1'b1;
            w_state_next = S_ERR;
          end else if (in_data != 8'hFF) begin
            w_state_next = S_COPY_RD;
          end
        end
      end

      S_COPY_RD: begin
        w_re         = 1'b1;
        w_state_next = S_COPY_WR;
      end

      S_COPY_WR: begin
        // r_ram_q only changes on a read, so it stays valid across output stalls.
        if (w_out_free) begin
          w_out_data_next  = r_ram_q;
          w_out_valid_next = 1'b1;
          w_out_last_next  = 1'b0;
          w_we             = 1'b1;
          w_wdata          = r_ram_q;
          w_wp_next        = r_wp + 1'b1;
          w_out_count_next = r_out_count + 32'd1;
          w_match_len_next = r_match_len - 32'd1;
          w_state_next     = (r_match_len == 32'd1) ? S_TOKEN : S_COPY_RD;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lit_len   <= 32'd0;
      r_ml_nib    <= 4'd0;
      r_offset    <= 16'd0;
      r_match_len <= 32'd0;
      r_wp        <= '0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_out_count <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_lit_len   <= w_lit_len_next;
      r_ml_nib    <= w_ml_nib_next;
      r_offset    <= w_offset_next;
      r_match_len <= w_match_len_next;
      r_wp        <= w_wp_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_out_last  <= w_out_last_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_out_count <= w_out_count_next;
    end
  end

  // History window: single port, registered read, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[r_wp] <= w_wdata;
    end
    if (w_re) begin
      r_ram_q <= r_mem[w_raddr];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign error     = r_error;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_lz4_block_decoder.sv
// Self-checking bench for lz4_block_decoder: table of blocks plus hand-written corner sequences,
// with a scoreboard queue of expected output bytes checked at every output handshake.
module tb_lz4_block_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;
  logic        error;
  logic [31:0] out_count;

  lz4_block_decoder #(.HIST_AW(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .done(done), .error(error), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    int                 n_in;
    logic [0:23][7:0]   din;
    int                 n_out;
    logic [0:31][7:0]   dout;
    bit                 exp_done;
    bit                 exp_err;
    bit                 rnd;
  } vec_t;

  vec_t        vecs [9];
  logic [8:0]  sb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rnd_mode = 1'b0;
  bit          ready_hold = 1'b1;
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_d;
  logic        prev_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // out_ready changes just after the rising edge and holds until the next one.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : ready_hold;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_checks++;
        if (!(out_valid === 1'b1 && out_data === prev_d && out_last === prev_l)) begin
          n_errors++;
          $display("FAIL stall_hold: got valid=%0b data=0x%0h last=%0b expected valid=1 data=0x%0h last=%0b",
                   out_valid, out_data, out_last, prev_d, prev_l);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_out: got unexpected byte 0x%0h expected no output", out_data);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
          chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  end

  task automatic set_vec(input int idx, input string nm, input int ni, input logic [0:23][7:0] di,
                         input int no, input logic [0:31][7:0] dq, input bit d, input bit e, input bit r);
    vecs[idx].name = nm;   vecs[idx].n_in = ni;  vecs[idx].din = di;
    vecs[idx].n_out = no;  vecs[idx].dout = dq;
    vecs[idx].exp_done = d; vecs[idx].exp_err = e; vecs[idx].rnd = r;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    ok = 1'b0;
    in_data = d; in_last = l; in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      if (error) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok && !error) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_timeout: got no acceptance of byte 0x%0h expected in_ready", d);
    end
  endtask

  task automatic wait_end();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((done || error) && sb.size() == 0) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    bit   ok;
    v = vecs[i];
    ready_hold = 1'b1;
    rnd_mode   = v.rnd;
    for (int j = 0; j < v.n_out; j++)
      sb.push_back({(v.exp_done && j == v.n_out - 1), v.dout[j]});
    pulse_start();
    for (int j = 0; j < v.n_in; j++) begin
      send_byte(v.din[j], (j == v.n_in - 1), ok);
      if (!ok) break;
    end
    wait_end();
    chk({v.name, "_done"},  {31'd0, done},  {31'd0, v.exp_done});
    chk({v.name, "_error"}, {31'd0, error}, {31'd0, v.exp_err});
    chk({v.name, "_count"}, out_count, v.n_out);
    chk({v.name, "_drained"}, sb.size(), 0);
    if (v.exp_err) chk({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    rnd_mode = 1'b0;
    sb.delete();
    $display("block %s: in=%0d out=%0d done=%0b error=%0b count=%0d",
             v.name, v.n_in, v.n_out, done, error, out_count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0;

    set_vec(0, "lit_abc", 4, {8'h30, 8'h41, 8'h42, 8'h43, {20{8'h00}}},
            3, {8'h41, 8'h42, 8'h43, {29{8'h00}}}, 1, 0, 0);
    set_vec(1, "overlap", 6, {8'h14, 8'h61, 8'h01, 8'h00, 8'h10, 8'h62, {18{8'h00}}},
            10, {{9{8'h61}}, 8'h62, {22{8'h00}}}, 1, 0, 0);
    set_vec(2, "overlap_bp", 6, {8'h14, 8'h61, 8'h01, 8'h00, 8'h10, 8'h62, {18{8'h00}}},
            10, {{9{8'h61}}, 8'h62, {22{8'h00}}}, 1, 0, 1);
    set_vec(3, "offset0", 4, {8'h10, 8'h78, 8'h00, 8'h00, {20{8'h00}}},
            1, {8'h78, {31{8'h00}}}, 0, 1, 0);
    set_vec(4, "offset_big", 4, {8'h10, 8'h78, 8'h02, 8'h00, {20{8'h00}}},
            1, {8'h78, {31{8'h00}}}, 0, 1, 0);
    set_vec(5, "token_end", 1, {8'h00, {23{8'h00}}},
            0, {32{8'h00}}, 1, 0, 0);
    set_vec(6, "last_off_lo", 3, {8'h10, 8'h78, 8'h01, {21{8'h00}}},
            1, {8'h78, {31{8'h00}}}, 0, 1, 0);
    set_vec(7, "mat_ext", 8, {8'h2F, 8'h61, 8'h62, 8'h02, 8'h00, 8'h01, 8'h10, 8'h63, {16{8'h00}}},
            23, {8'h61, 8'h62, {10{8'h61, 8'h62}}, 8'h63, {9{8'h00}}}, 1, 0, 0);
    set_vec(8, "early_last", 3, {8'h30, 8'h41, 8'h42, {21{8'h00}}},
            2, {8'h41, 8'h42, {30{8'h00}}}, 0, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_error",     {31'd0, error},     32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_count", out_count,          32'd0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Extended literal length: 15 + 255 + 2 = 272 literals.
    ready_hold = 1'b1;
    for (int j = 0; j < 272; j++)
      sb.push_back({(j == 271), 8'((j * 7 + 3) & 8'hFF)});
    pulse_start();
    send_byte(8'hF0, 1'b0, ok);
    send_byte(8'hFF, 1'b0, ok);
    send_byte(8'h02, 1'b0, ok);
    for (int j = 0; j < 272; j++) begin
      send_byte(8'((j * 7 + 3) & 8'hFF), (j == 271), ok);
      if (!ok) break;
    end
    wait_end();
    chk("extlit_done",    {31'd0, done},  32'd1);
    chk("extlit_error",   {31'd0, error}, 32'd0);
    chk("extlit_count",   out_count,      32'd272);
    chk("extlit_drained", sb.size(),      0);
    sb.delete();
    $display("block ext_lit: in=275 out=272 done=%0b error=%0b count=%0d", done, error, out_count);

    // Stall the output so the decoder parks in COPY_WR, then reset it there.
    ready_hold = 1'b0;
    repeat (2) @(posedge clk);
    pulse_start();
    send_byte(8'h14, 1'b0, ok);
    send_byte(8'h61, 1'b0, ok);
    send_byte(8'h01, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("park_out_valid", {31'd0, out_valid}, 32'd1);
    chk("park_in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data",  {24'd0, out_data},  32'd0);
    chk("mid_rst_out_last",  {31'd0, out_last},  32'd0);
    chk("mid_rst_done",      {31'd0, done},      32'd0);
    chk("mid_rst_error",     {31'd0, error},     32'd0);
    chk("mid_rst_count",     out_count,          32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    sb.delete();
    $display("block mid_rst: reset applied in copy state, outputs cleared");
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
